// File: rtl/terrain_writer.sv
// terrain_writer: procedural ground generator.
// Walks columns 0..WIDTH-1, derives each column height from an LFSR random
// walk, writes it to the ground RAM and plots the column's ground pixels.
//
// state | meaning
// IDLE  | waiting for start
// WRITE | one-cycle ground RAM write of the current column height
// DRAW  | one plot per cycle from y=h down to the bottom row (119)
// NEXT  | step to the next column, random-walk the height, advance LFSR
// DONE  | one-cycle done pulse, then back to IDLE
module terrain_writer #(
    parameter int          WIDTH   = 160,
    parameter int          MIN_H   = 60,
    parameter int          MAX_H   = 115,
    parameter int          START_H = 100,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] seed,
    output logic        busy,
    output logic        done,
    output logic [7:0]  ram_address,
    output logic [7:0]  ram_data,
    output logic        ram_wren,
    output logic [7:0]  pix_x,
    output logic [7:0]  pix_y,
    output logic [2:0]  pix_colour,
    output logic        pix_plot
);

    typedef enum logic [2:0] {IDLE, WRITE, DRAW, NEXT, DONE} state_t;

    localparam logic [7:0] LAST_COL = 8'(WIDTH - 1);
    localparam logic [7:0] LO_H     = 8'(MIN_H);
    localparam logic [7:0] HI_H     = 8'(MAX_H);
    localparam logic [7:0] BOTTOM_Y = 8'd119;

    state_t      state, next_state;
    logic [7:0]  col, col_n;
    logic [7:0]  h, h_n;
    logic [7:0]  y, y_n;
    logic [15:0] lfsr, lfsr_n;

    logic        busy_d, done_d, ram_wren_d, pix_plot_d;
    logic [7:0]  ram_address_d, ram_data_d, pix_x_d, pix_y_d;
    logic [2:0]  pix_colour_d;

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = WRITE;
            WRITE: next_state = DRAW;
            DRAW:  if (y == BOTTOM_Y) next_state = NEXT;
            NEXT:  next_state = (col == LAST_COL) ? DONE : WRITE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath next values: column walk, height random walk, LFSR step
    always_comb begin
        col_n  = col;
        h_n    = h;
        y_n    = y;
        lfsr_n = lfsr;
        case (state)
            IDLE: if (start) begin
                lfsr_n = (seed == 16'h0000) ? SEED : seed;
                h_n    = 8'(START_H);
                col_n  = 8'd0;
            end
            WRITE: y_n = h;
            DRAW:  if (y != BOTTOM_Y) y_n = y + 8'd1;
            NEXT: if (col != LAST_COL) begin
                col_n = col + 8'd1;
                // Saturate at the bounds so the decrement can never wrap.
                case (lfsr[1:0])
                    2'b00:   h_n = (h <= LO_H) ? LO_H : h - 8'd1;
                    2'b11:   h_n = (h >= HI_H) ? HI_H : h + 8'd1;
                    default: h_n = h;
                endcase
                lfsr_n = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            end
            default: ;
        endcase
    end

    // Output logic: decoded from the upcoming state so outputs land with it
    always_comb begin
        busy_d        = (next_state != IDLE);
        done_d        = (next_state == DONE);
        ram_wren_d    = 1'b0;
        ram_address_d = ram_address;
        ram_data_d    = ram_data;
        pix_plot_d    = 1'b0;
        pix_x_d       = pix_x;
        pix_y_d       = pix_y;
        pix_colour_d  = pix_colour;
        if (next_state == WRITE) begin
            ram_wren_d    = 1'b1;
            ram_address_d = col_n;
            ram_data_d    = h_n;
        end
        if (next_state == DRAW) begin
            pix_plot_d   = 1'b1;
            pix_x_d      = col_n;
            pix_y_d      = y_n;
            pix_colour_d = 3'b010;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            col         <= '0;
            h           <= '0;
            y           <= '0;
            lfsr        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ram_wren    <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
            pix_plot    <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_colour  <= '0;
        end else begin
            col         <= col_n;
            h           <= h_n;
            y           <= y_n;
            lfsr        <= lfsr_n;
            busy        <= busy_d;
            done        <= done_d;
            ram_wren    <= ram_wren_d;
            ram_address <= ram_address_d;
            ram_data    <= ram_data_d;
            pix_plot    <= pix_plot_d;
            pix_x       <= pix_x_d;
            pix_y       <= pix_y_d;
            pix_colour  <= pix_colour_d;
        end
    end

endmodule

// File: tb/tb_terrain_writer.sv
// Testbench for terrain_writer: directed runs checked against a software
// random-walk model of the ground heights.
module tb_terrain_writer;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] seed = 16'h0000;
    logic        busy, done, ram_wren, pix_plot;
    logic [7:0]  ram_address, ram_data, pix_x, pix_y;
    logic [2:0]  pix_colour;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_h   [160];
    logic [7:0] cap_addr[160];
    logic [7:0] cap_data[160];
    logic [7:0] ref_data[160];
    int         plot_cnt[160];
    int wr_count, cycles, plot_bad, busy_bad, first_bad;
    bit done_seen;

    terrain_writer dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .seed(seed),
        .busy(busy), .done(done), .ram_address(ram_address),
        .ram_data(ram_data), .ram_wren(ram_wren), .pix_x(pix_x),
        .pix_y(pix_y), .pix_colour(pix_colour), .pix_plot(pix_plot)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Reference random walk of the column heights
    task automatic model(input logic [15:0] s);
        logic [15:0] l;
        int hh;
        l  = (s == 16'h0000) ? 16'hACE1 : s;
        hh = 100;
        exp_h[0] = 8'(hh);
        for (int c = 1; c < 160; c++) begin
            if (l[1:0] == 2'b00)      hh = (hh <= 60)  ? 60  : hh - 1;
            else if (l[1:0] == 2'b11) hh = (hh >= 115) ? 115 : hh + 1;
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
            exp_h[c] = 8'(hh);
        end
    endtask

    function automatic int expected_cycles();
        int sum = 2;
        for (int c = 0; c < 160; c++) sum += 122 - int'(exp_h[c]);
        return sum;
    endfunction

    // Starts a run and samples every cycle at the falling edge.
    // mode 0: plain, 1: extra start pulse in column 10 DRAW,
    // 2: reset in column 37 DRAW (abort), 3: start held high throughout.
    task automatic capture(input logic [15:0] s, input int mode);
        bit pulsed = 0;
        bit stop = 0;
        int cx;
        model(s);
        wr_count = 0; cycles = 0; plot_bad = 0; busy_bad = 0; first_bad = 0;
        done_seen = 0;
        for (int c = 0; c < 160; c++) plot_cnt[c] = 0;
        seed  = s;
        start = 1'b1;
        while (!done_seen && !stop && cycles < 20000) begin
            @(negedge CLOCK_50);
            cycles++;
            start = (mode == 3);
            if (cycles == 1 && ram_wren !== 1'b1) first_bad++;
            if (cycles == 2 && pix_plot !== 1'b1) first_bad++;
            if (busy !== 1'b1) busy_bad++;
            if (ram_wren === 1'b1) begin
                if (wr_count < 160) begin
                    cap_addr[wr_count] = ram_address;
                    cap_data[wr_count] = ram_data;
                end
                wr_count++;
                if (pix_plot === 1'b1) plot_bad++;
            end
            if (pix_plot === 1'b1) begin
                cx = int'(pix_x);
                if (cx >= 160) plot_bad++;
                else begin
                    if (pix_colour !== 3'b010 ||
                        pix_y !== 8'(int'(exp_h[cx]) + plot_cnt[cx])) plot_bad++;
                    plot_cnt[cx]++;
                end
                if (mode == 1 && cx == 10 && !pulsed) begin
                    start  = 1'b1;
                    pulsed = 1;
                end
                if (mode == 2 && cx == 37) begin
                    reset = 1'b1;
                    stop  = 1;
                end
            end
            if (done === 1'b1) done_seen = 1;
        end
        if (!done_seen && !stop) begin
            errors++;
            $display("FAIL timeout: no done within %0d cycles", cycles);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        checks++;
        if ({busy, done, ram_wren, ram_address, ram_data, pix_plot, pix_x, pix_y, pix_colour} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b wren=%b addr=%0d data=%0d plot=%b x=%0d y=%0d col=%0d, all required 0",
                     busy, done, ram_wren, ram_address, ram_data, pix_plot, pix_x, pix_y, pix_colour);
        end
        reset = 1'b0;
        @(negedge CLOCK_50);
    endtask

    task automatic test_full_run();
        int bad_addr = 0, bad_data = 0, bad_range = 0, bad_step = 0, bad_cnt = 0, d;
        capture(16'h0001, 0);
        checks++;
        if (first_bad != 0) begin errors++; $display("FAIL first_latency: %0d latency errors, required 0", first_bad); end
        checks++;
        if (wr_count != 160) begin errors++; $display("FAIL write_count: got %0d, required 160", wr_count); end
        checks++;
        if (cap_data[0] !== 8'd100) begin errors++; $display("FAIL col0_data: got %0d, required 100", cap_data[0]); end
        for (int c = 0; c < 160; c++) begin
            if (cap_addr[c] !== 8'(c)) bad_addr++;
            if (cap_data[c] !== exp_h[c]) bad_data++;
            if (cap_data[c] < 8'd60 || cap_data[c] > 8'd115) bad_range++;
            if (c > 0) begin
                d = int'(cap_data[c]) - int'(cap_data[c-1]);
                if (d < -1 || d > 1) bad_step++;
            end
            if (plot_cnt[c] != 120 - int'(exp_h[c])) bad_cnt++;
        end
        checks++;
        if (bad_addr != 0) begin errors++; $display("FAIL addr_order: %0d bad addresses, required 0", bad_addr); end
        checks++;
        if (bad_data != 0) begin errors++; $display("FAIL data_model: %0d mismatching heights, required 0", bad_data); end
        checks++;
        if (bad_range + bad_step != 0) begin errors++; $display("FAIL range_step: %0d range, %0d step violations, required 0", bad_range, bad_step); end
        checks++;
        if (bad_cnt != 0 || plot_bad != 0) begin errors++; $display("FAIL plots: %0d bad counts, %0d bad plots, required 0", bad_cnt, plot_bad); end
        checks++;
        if (plot_cnt[0] != 20) begin errors++; $display("FAIL col0_plots: got %0d, required 20", plot_cnt[0]); end
        checks++;
        if (cycles + 1 != expected_cycles()) begin errors++; $display("FAIL run_cycles: got %0d, required %0d", cycles + 1, expected_cycles()); end
        checks++;
        if (busy_bad != 0) begin errors++; $display("FAIL busy_high: %0d low cycles, required 0", busy_bad); end
        @(negedge CLOCK_50);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL after_done: done=%b busy=%b, required 0 0", done, busy); end
    endtask

    task automatic test_seed_zero();
        int diff = 0;
        capture(16'hACE1, 0);
        for (int c = 0; c < 160; c++) ref_data[c] = cap_data[c];
        @(negedge CLOCK_50);
        capture(16'h0000, 0);
        for (int c = 0; c < 160; c++) if (cap_data[c] !== ref_data[c] || cap_data[c] !== exp_h[c]) diff++;
        checks++;
        if (diff != 0 || wr_count != 160) begin
            errors++;
            $display("FAIL seed_zero: %0d differences, %0d writes, required 0 and 160", diff, wr_count);
        end
        @(negedge CLOCK_50);
    endtask

    task automatic test_restart_ignored();
        int bad = 0;
        capture(16'h0001, 1);
        for (int c = 0; c < 160; c++) if (cap_data[c] !== exp_h[c] || cap_addr[c] !== 8'(c)) bad++;
        checks++;
        if (bad != 0 || wr_count != 160 || cycles + 1 != expected_cycles()) begin
            errors++;
            $display("FAIL start_ignored: %0d bad, %0d writes, %0d cycles, required 0, 160, %0d",
                     bad, wr_count, cycles + 1, expected_cycles());
        end
        @(negedge CLOCK_50);
    endtask

    task automatic test_hold_start();
        capture(16'h1234, 3);
        checks++;
        if (wr_count != 160) begin errors++; $display("FAIL hold_run_writes: got %0d, required 160", wr_count); end
        @(negedge CLOCK_50);
        checks++;
        if (busy !== 1'b0 || ram_wren !== 1'b0) begin errors++; $display("FAIL hold_idle: busy=%b wren=%b, required 0 0", busy, ram_wren); end
        @(negedge CLOCK_50);
        checks++;
        if (ram_wren !== 1'b1 || ram_address !== 8'd0 || ram_data !== 8'd100 || busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_restart: wren=%b addr=%0d data=%0d busy=%b, required 1 0 100 1",
                     ram_wren, ram_address, ram_data, busy);
        end
        start = 1'b0;
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
    endtask

    task automatic test_reset_midrun();
        int quiet_bad = 0, bad = 0;
        capture(16'h0001, 2);
        @(negedge CLOCK_50);
        reset = 1'b0;
        checks++;
        if ({busy, done, ram_wren, ram_address, ram_data, pix_plot, pix_x, pix_y, pix_colour} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: busy=%b wren=%b addr=%0d plot=%b x=%0d y=%0d, all required 0",
                     busy, ram_wren, ram_address, pix_plot, pix_x, pix_y);
        end
        repeat (4) begin
            @(negedge CLOCK_50);
            if (busy !== 1'b0 || ram_wren !== 1'b0 || pix_plot !== 1'b0) quiet_bad++;
        end
        checks++;
        if (quiet_bad != 0) begin errors++; $display("FAIL abort_idle: %0d active cycles, required 0", quiet_bad); end
        capture(16'h0001, 0);
        for (int c = 0; c < 160; c++) if (cap_data[c] !== exp_h[c] || cap_addr[c] !== 8'(c)) bad++;
        checks++;
        if (bad != 0 || wr_count != 160) begin
            errors++;
            $display("FAIL rerun: %0d bad, %0d writes, required 0 and 160", bad, wr_count);
        end
        @(negedge CLOCK_50);
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_seed_zero();
        test_restart_ignored();
        test_hold_start();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
